// File: rtl/mem_arb_ctlr.sv
// Round-robin arbiter of per-channel request slots in front of a single-port memory.
// Each grant runs IDLE -> ACCESS (1+WAIT_CYC cycles) -> RESP; done pulses are registered.
module mem_arb_ctlr #(
  parameter int unsigned N_CH     = 2,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DEPTH    = 512,
  parameter int unsigned WAIT_CYC = 0
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [N_CH-1:0]          req_rd,
  input  logic [N_CH-1:0]          req_wr,
  input  logic [N_CH*ADDR_W-1:0]   req_addr,
  input  logic [N_CH*DATA_W-1:0]   req_wdata,
  output logic [N_CH-1:0]          rd_dn,
  output logic [N_CH-1:0]          wr_dn,
  output logic [N_CH-1:0]          err,
  output logic [N_CH-1:0]          ovr,
  output logic [ADDR_W-1:0]        dn_addr,
  output logic [DATA_W-1:0]        dn_data,
  output logic                     busy
);
  localparam int unsigned GW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DepthL  = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      LastCnt = 4'(WAIT_CYC);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e                        state_q, state_d;
  logic   [3:0]                  cnt_q, cnt_d;
  logic   [GW-1:0]               grant_q, grant_d, ptr_q, ptr_d;
  logic   [N_CH-1:0]             pend_q, op_wr_q;
  logic   [N_CH-1:0][ADDR_W-1:0] addr_q;
  logic   [N_CH-1:0][DATA_W-1:0] wdata_q;
  logic   [N_CH-1:0]             req_any, acc, clr, pend_now;
  logic   [N_CH-1:0]             rd_dn_q, wr_dn_q, err_q, ovr_q;
  logic   [ADDR_W-1:0]           dn_addr_q;
  logic   [DATA_W-1:0]           dn_data_q;
  logic                          oor_q;
  logic                          win_found, do_mem, do_done, oor, g_wr;
  logic   [GW-1:0]               win_idx, cand;
  logic   [ADDR_W-1:0]           g_addr;
  logic   [DATA_W-1:0]           g_wdata;
  logic   [MW-1:0]               maddr;
  logic   [DATA_W-1:0]           mem [DEPTH];

  assign g_addr  = addr_q[grant_q];
  assign g_wdata = wdata_q[grant_q];
  assign g_wr    = op_wr_q[grant_q];
  assign maddr   = g_addr[MW-1:0];
  assign oor     = ({1'b0, g_addr} >= DepthL);

  // The granted slot frees on the RESP edge and may be refilled on that same edge.
  always_comb begin
    clr = '0;
    if (state_q == StResp) clr[grant_q] = 1'b1;
  end

  assign req_any  = req_rd | req_wr;
  assign acc      = req_any & (~pend_q | clr);
  assign pend_now = pend_q | acc;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= int'(N_CH); i++) begin
      cand = GW'((int'(ptr_q) + i) % int'(N_CH));
      if (!win_found && pend_now[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    do_mem  = 1'b0;
    do_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d = StAccess;
          grant_d = win_idx;
          ptr_d   = win_idx;
          cnt_d   = '0;
        end
      end
      StAccess: begin
        if (cnt_q == LastCnt) begin
          do_mem  = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StResp: begin
        do_done = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      grant_q   <= '0;
      ptr_q     <= GW'(N_CH - 1);
      pend_q    <= '0;
      ovr_q     <= '0;
      rd_dn_q   <= '0;
      wr_dn_q   <= '0;
      err_q     <= '0;
      oor_q     <= 1'b0;
      dn_addr_q <= '0;
      dn_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      pend_q  <= (pend_q & ~clr) | acc;
      ovr_q   <= ovr_q | (req_any & ~acc);
      rd_dn_q <= '0;
      wr_dn_q <= '0;
      err_q   <= '0;
      if (do_mem) begin
        dn_addr_q <= g_addr;
        oor_q     <= oor;
        if (g_wr)     dn_data_q <= g_wdata;
        else if (oor) dn_data_q <= '0;
        else          dn_data_q <= mem[maddr];
      end
      if (do_done) begin
        if (g_wr) wr_dn_q[grant_q] <= 1'b1;
        else      rd_dn_q[grant_q] <= 1'b1;
        err_q[grant_q] <= oor_q;
      end
    end
  end

  // Slot payload needs no reset: pend_q alone says whether it is meaningful.
  always_ff @(posedge CLK) begin
    for (int c = 0; c < int'(N_CH); c++) begin
      if (acc[c]) begin
        op_wr_q[c] <= req_wr[c];
        addr_q[c]  <= req_addr[c*ADDR_W +: ADDR_W];
        wdata_q[c] <= req_wdata[c*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET && do_mem && g_wr && !oor) mem[maddr] <= g_wdata;
  end

  assign rd_dn   = rd_dn_q;
  assign wr_dn   = wr_dn_q;
  assign err     = err_q;
  assign ovr     = ovr_q;
  assign dn_addr = dn_addr_q;
  assign dn_data = dn_data_q;
  assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arb_ctlr.sv
// Scoreboard bench for mem_arb_ctlr: one instance with WAIT_CYC=0 and one with WAIT_CYC=3.
module tb_mem_arb_ctlr;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst0, rst3;
  logic [1:0]  rd0, wr0, rd3, wr3;
  logic [31:0] addr0, addr3;
  logic [63:0] wdata0, wdata3;
  logic [1:0]  rd_dn0, wr_dn0, err0, ovr0, rd_dn3, wr_dn3, err3, ovr3;
  logic [15:0] dn_addr0, dn_addr3;
  logic [31:0] dn_data0, dn_data3;
  logic        busy0, busy3;

  mem_arb_ctlr #(.N_CH(2), .DATA_W(32), .ADDR_W(16), .DEPTH(512), .WAIT_CYC(0)) u_dut0 (
    .CLK(CLK), .RESET(rst0), .req_rd(rd0), .req_wr(wr0), .req_addr(addr0),
    .req_wdata(wdata0), .rd_dn(rd_dn0), .wr_dn(wr_dn0), .err(err0), .ovr(ovr0),
    .dn_addr(dn_addr0), .dn_data(dn_data0), .busy(busy0)
  );

  mem_arb_ctlr #(.N_CH(2), .DATA_W(32), .ADDR_W(16), .DEPTH(512), .WAIT_CYC(3)) u_dut3 (
    .CLK(CLK), .RESET(rst3), .req_rd(rd3), .req_wr(wr3), .req_addr(addr3),
    .req_wdata(wdata3), .rd_dn(rd_dn3), .wr_dn(wr_dn3), .err(err3), .ovr(ovr3),
    .dn_addr(dn_addr3), .dn_data(dn_data3), .busy(busy3)
  );

  typedef struct {
    logic        wr;
    int          ch;
    logic [15:0] addr;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q3[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic void check_done(string tag, exp_t e, logic [1:0] rd, logic [1:0] wr,
                                     logic [1:0] er, logic [15:0] a, logic [31:0] d);
    logic [3:0] ev;
    logic [1:0] ee;
    ev = '0;
    ee = '0;
    if (e.wr) ev[2 + e.ch] = 1'b1;
    else      ev[e.ch] = 1'b1;
    if (e.err) ee[e.ch] = 1'b1;
    chk({tag, " done{wr,rd}"}, 64'({wr, rd}), 64'(ev));
    chk({tag, " err"}, 64'(er), 64'(ee));
    chk({tag, " dn_addr"}, 64'(a), 64'(e.addr));
    chk({tag, " dn_data"}, 64'(d), 64'(e.data));
    chk({tag, " done cycle"}, 64'(cyc), 64'(e.cyc));
  endfunction

  always @(negedge CLK) begin
    if ((rd_dn0 | wr_dn0) != 2'b00) begin
      if (q0.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL d0 unexpected done: got rd=%b wr=%b, expected none", rd_dn0, wr_dn0);
      end else begin
        check_done("d0", q0.pop_front(), rd_dn0, wr_dn0, err0, dn_addr0, dn_data0);
      end
    end
    if ((rd_dn3 | wr_dn3) != 2'b00) begin
      if (q3.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL d3 unexpected done: got rd=%b wr=%b, expected none", rd_dn3, wr_dn3);
      end else begin
        check_done("d3", q3.pop_front(), rd_dn3, wr_dn3, err3, dn_addr3, dn_data3);
      end
    end
  end

  function automatic void push(int inst, logic wr, int ch, logic [15:0] a, logic [31:0] d,
                               logic e, int c);
    exp_t x;
    x.wr = wr; x.ch = ch; x.addr = a; x.data = d; x.err = e; x.cyc = c;
    if (inst == 0) q0.push_back(x);
    else           q3.push_back(x);
  endfunction

  // Called at a negedge; t returns the cycle number of the sampling edge.
  task automatic drive(input int inst, input logic [1:0] rdm, input logic [1:0] wrm,
                       input logic [15:0] a0, input logic [15:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1, output int t);
    if (inst == 0) begin
      rd0 = rdm; wr0 = wrm; addr0 = {a1, a0}; wdata0 = {d1, d0};
    end else begin
      rd3 = rdm; wr3 = wrm; addr3 = {a1, a0}; wdata3 = {d1, d0};
    end
    t = cyc + 1;
    @(negedge CLK);
    if (inst == 0) begin rd0 = '0; wr0 = '0; end
    else           begin rd3 = '0; wr3 = '0; end
  endtask

  task automatic wait_idle(input int inst);
    int  n;
    logic done;
    n = 0;
    done = 1'b0;
    while (!done && n < 60) begin
      @(negedge CLK);
      n++;
      if (inst == 0) done = (q0.size() == 0) && !busy0;
      else           done = (q3.size() == 0) && !busy3;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle d%0d: timed out after %0d cycles, expected completion", inst, n);
    end
    @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, t2;
    rst0 = 1'b1; rst3 = 1'b1;
    rd0 = '0; wr0 = '0; addr0 = '0; wdata0 = '0;
    rd3 = '0; wr3 = '0; addr3 = '0; wdata3 = '0;
    repeat (3) @(negedge CLK);
    chk("reset busy0", 64'(busy0), 64'd0);
    chk("reset outs0", 64'({ovr0, err0, wr_dn0, rd_dn0}), 64'd0);
    chk("reset busy3", 64'(busy3), 64'd0);
    chk("reset outs3", 64'({ovr3, err3, wr_dn3, rd_dn3}), 64'd0);
    rst0 = 1'b0; rst3 = 1'b0;
    @(negedge CLK);

    // Write then read back, WAIT_CYC=0
    drive(0, 2'b00, 2'b01, 16'd5, 16'd0, 32'hDEADBEEF, 32'd0, t);
    push(0, 1'b1, 0, 16'd5, 32'hDEADBEEF, 1'b0, t + 2);
    wait_idle(0);
    drive(0, 2'b01, 2'b00, 16'd5, 16'd0, 32'd0, 32'd0, t);
    push(0, 1'b0, 0, 16'd5, 32'hDEADBEEF, 1'b0, t + 2);
    wait_idle(0);
    drive(0, 2'b00, 2'b10, 16'd0, 16'd88, 32'd0, 32'hA5A5A5A5, t);
    push(0, 1'b1, 1, 16'd88, 32'hA5A5A5A5, 1'b0, t + 2);
    wait_idle(0);

    // Contention right after reset, twice
    rst0 = 1'b1;
    @(negedge CLK);
    rst0 = 1'b0;
    chk("post-reset busy0", 64'(busy0), 64'd0);
    for (int k = 0; k < 2; k++) begin
      drive(0, 2'b11, 2'b00, 16'd5, 16'd88, 32'd0, 32'd0, t);
      push(0, 1'b0, 0, 16'd5, 32'hDEADBEEF, 1'b0, t + 2);
      push(0, 1'b0, 1, 16'd88, 32'hA5A5A5A5, 1'b0, t + 5);
      wait_idle(0);
    end

    // Write priority, then overrun on a still-pending slot
    drive(0, 2'b10, 2'b10, 16'd0, 16'd7, 32'd0, 32'h11112222, t);
    push(0, 1'b1, 1, 16'd7, 32'h11112222, 1'b0, t + 2);
    drive(0, 2'b10, 2'b00, 16'd0, 16'd9, 32'd0, 32'd0, t2);
    chk("ovr after drop", 64'(ovr0), 64'h2);
    wait_idle(0);
    drive(0, 2'b01, 2'b00, 16'd7, 16'd0, 32'd0, 32'd0, t);
    push(0, 1'b0, 0, 16'd7, 32'h11112222, 1'b0, t + 2);
    wait_idle(0);

    // Out-of-range accesses; 600 aliases 88 if the range check were missing
    drive(0, 2'b01, 2'b00, 16'd600, 16'd0, 32'd0, 32'd0, t);
    push(0, 1'b0, 0, 16'd600, 32'd0, 1'b1, t + 2);
    wait_idle(0);
    drive(0, 2'b00, 2'b01, 16'd600, 16'd0, 32'h1234, 32'd0, t);
    push(0, 1'b1, 0, 16'd600, 32'h1234, 1'b1, t + 2);
    wait_idle(0);
    drive(0, 2'b10, 2'b00, 16'd0, 16'd88, 32'd0, 32'd0, t);
    push(0, 1'b0, 1, 16'd88, 32'hA5A5A5A5, 1'b0, t + 2);
    wait_idle(0);

    // New request on the edge the slot is freed
    drive(0, 2'b01, 2'b00, 16'd5, 16'd0, 32'd0, 32'd0, t);
    push(0, 1'b0, 0, 16'd5, 32'hDEADBEEF, 1'b0, t + 2);
    @(negedge CLK);
    drive(0, 2'b01, 2'b00, 16'd88, 16'd0, 32'd0, 32'd0, t2);
    push(0, 1'b0, 0, 16'd88, 32'hA5A5A5A5, 1'b0, t2 + 3);
    wait_idle(0);
    chk("ovr sticky, no new", 64'(ovr0), 64'h2);

    // WAIT_CYC=3 latency
    drive(3, 2'b00, 2'b01, 16'd20, 16'd0, 32'hCAFEF00D, 32'd0, t);
    push(3, 1'b1, 0, 16'd20, 32'hCAFEF00D, 1'b0, t + 5);
    wait_idle(3);
    drive(3, 2'b10, 2'b00, 16'd0, 16'd20, 32'd0, 32'd0, t);
    push(3, 1'b0, 1, 16'd20, 32'hCAFEF00D, 1'b0, t + 5);
    wait_idle(3);

    // Reset during ACCESS aborts the write
    drive(3, 2'b00, 2'b01, 16'd20, 16'd0, 32'h0BADBEEF, 32'd0, t);
    rst3 = 1'b1;
    @(negedge CLK);
    rst3 = 1'b0;
    chk("abort busy3", 64'(busy3), 64'd0);
    chk("abort ovr3", 64'(ovr3), 64'd0);
    repeat (10) @(negedge CLK);
    drive(3, 2'b01, 2'b00, 16'd20, 16'd0, 32'd0, 32'd0, t);
    push(3, 1'b0, 0, 16'd20, 32'hCAFEF00D, 1'b0, t + 5);
    wait_idle(3);

    chk("q0 drained", 64'(q0.size()), 64'd0);
    chk("q3 drained", 64'(q3.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
